// File: rtl/mac_stop_ctrl_if.sv
// Bus bundle between mac_stop_ctrl and the start/done handshake plus the
// mac_stop_mem read/write ports. master = controller side, slave = the
// environment (top-level requester and memory).
interface mac_stop_ctrl_if #(
  parameter int M                      = 3,
  parameter int K                      = 5,
  parameter int N                      = 5,
  parameter int DATA_WIDTH_INIT_MATRIX = 32
);
  localparam int DATA_WIDTH_RESULT_MATRIX = 2*DATA_WIDTH_INIT_MATRIX + $clog2(K);
  localparam int AM = $clog2(M);
  localparam int AK = $clog2(K);
  localparam int AN = $clog2(N);

  logic                                start;
  logic                                busy;
  logic                                done;
  logic [AM-1:0]                       row_addr_a;
  logic [AK-1:0]                       col_addr_a;
  logic [AK-1:0]                       row_addr_b;
  logic [AN-1:0]                       col_addr_b;
  logic [AM-1:0]                       row_addr_c;
  logic [AN-1:0]                       col_addr_c;
  logic                                matrix_a_re;
  logic                                matrix_b_re;
  logic                                matrix_c_we;
  logic                                matrix_a_we;
  logic                                matrix_b_we;
  logic                                matrix_c_re;
  logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c;
  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_a;
  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_b;

  modport master (
    input  start, data_out_a, data_out_b,
    output busy, done,
    output row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c,
    output matrix_a_re, matrix_b_re, matrix_c_we, matrix_a_we, matrix_b_we, matrix_c_re,
    output data_in_c
  );

  modport slave (
    output start, data_out_a, data_out_b,
    input  busy, done,
    input  row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c,
    input  matrix_a_re, matrix_b_re, matrix_c_we, matrix_a_we, matrix_b_we, matrix_c_re,
    input  data_in_c
  );
endinterface

// File: rtl/mac_stop_ctrl.sv
// mac_stop_ctrl: sequencer that reads A (MxK) and B (KxN) from mac_stop_mem,
// accumulates C = A*B one element at a time (K+2 cycles per element) and
// writes C back row-major.
// Optional feature: define MAC_STOP_CTRL_CYCLE_CNT_EN to add the cycle_count
// output (busy cycles of the last run).
module mac_stop_ctrl #(
  parameter int M                      = 3,
  parameter int K                      = 5,
  parameter int N                      = 5,
  parameter int DATA_WIDTH_INIT_MATRIX = 32
) (
  input  logic            clk,
  input  logic            resetn,
  mac_stop_ctrl_if.master bus
`ifdef MAC_STOP_CTRL_CYCLE_CNT_EN
  ,
  output logic [31:0]     cycle_count
`endif
);
  localparam int DW = DATA_WIDTH_INIT_MATRIX;
  localparam int RW = 2*DATA_WIDTH_INIT_MATRIX + $clog2(K);
  localparam int AM = $clog2(M);
  localparam int AK = $clog2(K);
  localparam int AN = $clog2(N);

  localparam logic [AM-1:0] M_LAST = AM'(M-1);
  localparam logic [AK-1:0] K_LAST = AK'(K-1);
  localparam logic [AN-1:0] N_LAST = AN'(N-1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [AM-1:0] i_q, i_nxt;
  logic [AK-1:0] k_q, k_nxt;
  logic [AN-1:0] j_q, j_nxt;

  logic          vld_p1;
  logic          first_p1;
  logic [RW-1:0] acc_p1;

  // Full-precision unsigned product, zero-extended to the accumulator width.
  function automatic logic [RW-1:0] widen_prod(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    return RW'(p);
  endfunction

  // State and loop-counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      i_q   <= '0;
      k_q   <= '0;
      j_q   <= '0;
    end else begin
      state <= state_nxt;
      i_q   <= i_nxt;
      k_q   <= k_nxt;
      j_q   <= j_nxt;
    end
  end

  // Next-state and counter update: k walks the dot product, j then i walk C row-major.
  always_comb begin
    state_nxt = state;
    i_nxt     = i_q;
    k_nxt     = k_q;
    j_nxt     = j_q;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_ISSUE;
          i_nxt     = '0;
          k_nxt     = '0;
          j_nxt     = '0;
        end
      end
      S_ISSUE: begin
        if (k_q == K_LAST) begin
          k_nxt     = '0;
          state_nxt = S_DRAIN;
        end else begin
          k_nxt = k_q + 1'b1;
        end
      end
      S_DRAIN: state_nxt = S_WRITE;
      S_WRITE: begin
        state_nxt = S_ISSUE;
        if (j_q == N_LAST) begin
          j_nxt = '0;
          if (i_q == M_LAST) begin
            i_nxt     = '0;
            state_nxt = S_DONE;
          end else begin
            i_nxt = i_q + 1'b1;
          end
        end else begin
          j_nxt = j_q + 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read-return stage: memory data arrives one cycle after the read was issued.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      acc_p1   <= '0;
    end else begin
      vld_p1   <= (state == S_ISSUE);
      first_p1 <= (state == S_ISSUE) && (k_q == '0);
      if (vld_p1)
        acc_p1 <= (first_p1 ? '0 : acc_p1) + widen_prod(bus.data_out_a, bus.data_out_b);
    end
  end

  // Outputs decoded only from registered state, counters and accumulator.
  always_comb begin
    bus.busy        = (state == S_ISSUE) || (state == S_DRAIN) || (state == S_WRITE);
    bus.done        = (state == S_DONE);
    bus.matrix_a_re = (state == S_ISSUE);
    bus.matrix_b_re = (state == S_ISSUE);
    bus.matrix_c_we = (state == S_WRITE);
    bus.matrix_a_we = 1'b0;
    bus.matrix_b_we = 1'b0;
    bus.matrix_c_re = 1'b0;
    bus.row_addr_a  = i_q;
    bus.col_addr_a  = k_q;
    bus.row_addr_b  = k_q;
    bus.col_addr_b  = j_q;
    bus.row_addr_c  = i_q;
    bus.col_addr_c  = j_q;
    bus.data_in_c   = (state == S_WRITE) ? acc_p1 : '0;
  end

`ifdef MAC_STOP_CTRL_CYCLE_CNT_EN
  // Run-length counter: cleared on start accept, counts every busy cycle, then holds.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      cycle_count <= '0;
    else if ((state == S_IDLE) && bus.start)
      cycle_count <= '0;
    else if ((state == S_ISSUE) || (state == S_DRAIN) || (state == S_WRITE))
      cycle_count <= cycle_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mac_stop_ctrl.sv
// Directed bench for mac_stop_ctrl: a 2x2x2 instance and a default 3x5x5
// instance, each attached to a small memory model with one-cycle read latency.
module tb_mac_stop_ctrl;
  localparam int RWS = 65;
  localparam int RWB = 67;

  logic clk = 1'b0;
  logic rstn_s, rstn_b;
  logic clr_s, clr_b;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mac_stop_ctrl_if #(.M(2), .K(2), .N(2), .DATA_WIDTH_INIT_MATRIX(32)) bs ();
  mac_stop_ctrl_if #(.M(3), .K(5), .N(5), .DATA_WIDTH_INIT_MATRIX(32)) bb ();

`ifdef MAC_STOP_CTRL_CYCLE_CNT_EN
  logic [31:0] cc_s, cc_b;
`endif

  mac_stop_ctrl #(.M(2), .K(2), .N(2), .DATA_WIDTH_INIT_MATRIX(32)) dut_s (
    .clk(clk), .resetn(rstn_s), .bus(bs)
`ifdef MAC_STOP_CTRL_CYCLE_CNT_EN
    , .cycle_count(cc_s)
`endif
  );

  mac_stop_ctrl #(.M(3), .K(5), .N(5), .DATA_WIDTH_INIT_MATRIX(32)) dut_b (
    .clk(clk), .resetn(rstn_b), .bus(bb)
`ifdef MAC_STOP_CTRL_CYCLE_CNT_EN
    , .cycle_count(cc_b)
`endif
  );

  // Memory contents and write logs
  logic [31:0]    a_s [2][2];
  logic [31:0]    b_s [2][2];
  logic [31:0]    a_b [3][5];
  logic [31:0]    b_b [5][5];
  int             wcnt_s, wcnt_b, dcnt_s;
  int             wr_row_s [16], wr_col_s [16], wr_row_b [16], wr_col_b [16];
  logic [RWS-1:0] wr_dat_s [16];
  logic [RWB-1:0] wr_dat_b [16];

  always @(posedge clk) begin
    if (bs.matrix_a_re) bs.data_out_a <= a_s[bs.row_addr_a][bs.col_addr_a];
    if (bs.matrix_b_re) bs.data_out_b <= b_s[bs.row_addr_b][bs.col_addr_b];
    if (clr_s) begin
      wcnt_s <= 0;
      dcnt_s <= 0;
    end else begin
      if (bs.matrix_c_we) begin
        if (wcnt_s < 16) begin
          wr_row_s[wcnt_s] <= int'(bs.row_addr_c);
          wr_col_s[wcnt_s] <= int'(bs.col_addr_c);
          wr_dat_s[wcnt_s] <= bs.data_in_c;
        end
        wcnt_s <= wcnt_s + 1;
      end
      if (bs.done) dcnt_s <= dcnt_s + 1;
    end
  end

  always @(posedge clk) begin
    if (bb.matrix_a_re) bb.data_out_a <= a_b[bb.row_addr_a][bb.col_addr_a];
    if (bb.matrix_b_re) bb.data_out_b <= b_b[bb.row_addr_b][bb.col_addr_b];
    if (clr_b) begin
      wcnt_b <= 0;
    end else if (bb.matrix_c_we) begin
      if (wcnt_b < 16) begin
        wr_row_b[wcnt_b] <= int'(bb.row_addr_c);
        wr_col_b[wcnt_b] <= int'(bb.col_addr_c);
        wr_dat_b[wcnt_b] <= bb.data_in_c;
      end
      wcnt_b <= wcnt_b + 1;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_b(input logic [31:0] av, input logic [31:0] bv);
    for (int r = 0; r < 3; r++) for (int c = 0; c < 5; c++) a_b[r][c] = av;
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) b_b[r][c] = bv;
  endtask

  task automatic clear_logs();
    @(negedge clk);
    clr_s = 1'b1;
    clr_b = 1'b1;
    @(negedge clk);
    clr_s = 1'b0;
    clr_b = 1'b0;
  endtask

  // Start pulse; returns at the negedge after the accepting edge (clock 1 follows).
  task automatic kick_s(input bit hold);
    @(negedge clk);
    bs.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) bs.start = 1'b0;
  endtask

  task automatic kick_b();
    @(negedge clk);
    bb.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bb.start = 1'b0;
  endtask

  // Returns the index of the clock edge that samples done high.
  task automatic wait_done_s(output int at);
    int c;
    c = 1;
    while (!bs.done && c < 400) begin
      @(negedge clk);
      c++;
    end
    if (!bs.done) check("s_done_timeout", 0, 1);
    at = c;
  endtask

  task automatic wait_done_b(output int at);
    int c;
    c = 1;
    while (!bb.done && c < 400) begin
      @(negedge clk);
      c++;
    end
    if (!bb.done) check("b_done_timeout", 0, 1);
    at = c;
  endtask

  task automatic check_writes_b(input logic [RWB-1:0] exp);
    check("b_wr_count", wcnt_b, 15);
    for (int e = 0; e < 15; e++) begin
      check($sformatf("b_wr%0d_addr", e), {wr_row_b[e], wr_col_b[e]}, {e / 5, e % 5});
      check($sformatf("b_wr%0d_data", e), wr_dat_b[e], exp);
    end
  endtask

  task automatic check_idle_outputs_b(input string tag);
    check({tag, "_ctl"}, {bb.busy, bb.done, bb.matrix_a_re, bb.matrix_b_re, bb.matrix_c_we,
                          bb.matrix_a_we, bb.matrix_b_we, bb.matrix_c_re}, 0);
    check({tag, "_addr"}, {bb.row_addr_a, bb.col_addr_a, bb.row_addr_b, bb.col_addr_b,
                           bb.row_addr_c, bb.col_addr_c}, 0);
    check({tag, "_dc"}, bb.data_in_c, 0);
  endtask

  initial begin
    int at;
    int found;
    logic [RWS-1:0] exp_s [4];

    rstn_s = 1'b0;
    rstn_b = 1'b0;
    clr_s  = 1'b1;
    clr_b  = 1'b1;
    bs.start = 1'b0;
    bb.start = 1'b0;
    a_s[0][0] = 32'd1; a_s[0][1] = 32'd2; a_s[1][0] = 32'd3; a_s[1][1] = 32'd4;
    b_s[0][0] = 32'd5; b_s[0][1] = 32'd6; b_s[1][0] = 32'd7; b_s[1][1] = 32'd8;
    exp_s[0] = 65'd19; exp_s[1] = 65'd22; exp_s[2] = 65'd43; exp_s[3] = 65'd50;
    fill_b(32'd4, 32'd6);

    repeat (3) @(negedge clk);
    check("rst_s_ctl", {bs.busy, bs.done, bs.matrix_a_re, bs.matrix_b_re, bs.matrix_c_we,
                        bs.matrix_a_we, bs.matrix_b_we, bs.matrix_c_re}, 0);
    check("rst_s_addr", {bs.row_addr_a, bs.col_addr_a, bs.row_addr_b, bs.col_addr_b,
                         bs.row_addr_c, bs.col_addr_c}, 0);
    check("rst_s_dc", bs.data_in_c, 0);
    check_idle_outputs_b("rst_b");
`ifdef MAC_STOP_CTRL_CYCLE_CNT_EN
    check("rst_s_cc", cc_s, 0);
`endif
    rstn_s = 1'b1;
    rstn_b = 1'b1;
    clr_s  = 1'b0;
    clr_b  = 1'b0;
    repeat (2) @(negedge clk);

    // 2x2x2 reference product
    kick_s(1'b0);
    check("s_busy_after_start", bs.busy, 1);
    wait_done_s(at);
    check("s_done_at", at, 17);
`ifdef MAC_STOP_CTRL_CYCLE_CNT_EN
    check("s_cc_at_done", cc_s, 16);
`endif
    check("s_wr_count", wcnt_s, 4);
    for (int e = 0; e < 4; e++) begin
      check($sformatf("s_wr%0d_addr", e), {wr_row_s[e], wr_col_s[e]}, {e / 2, e % 2});
      check($sformatf("s_wr%0d_data", e), wr_dat_s[e], exp_s[e]);
    end
    @(negedge clk);
    check("s_done_one_cycle", bs.done, 0);
    repeat (3) @(negedge clk);
`ifdef MAC_STOP_CTRL_CYCLE_CNT_EN
    check("s_cc_held", cc_s, 16);
`endif

    // 3x5x5, A=4, B=6 -> 120 everywhere
    clear_logs();
    kick_b();
    wait_done_b(at);
    check("b46_done_at", at, 106);
    check_writes_b(67'd120);

    // 3x5x5 all ones -> full-width sums
    fill_b(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    clear_logs();
    kick_b();
    wait_done_b(at);
    check("bff_done_at", at, 106);
    check_writes_b(67'h4_FFFF_FFF6_0000_0005);

    // start held high across the whole run
    clear_logs();
    kick_s(1'b1);
    wait_done_s(at);
    check("held_done_at", at, 17);
    @(negedge clk);
    check("held_idle_busy", bs.busy, 0);
    check("held_idle_done", bs.done, 0);
    check("held_done_count", dcnt_s, 1);
    check("held_wr_count", wcnt_s, 4);
    @(negedge clk);
    check("held_restart_busy", bs.busy, 1);
    bs.start = 1'b0;
    wait_done_s(at);
    check("held_second_done_at", at, 17);

    // reset asserted during the WRITE of C(1,2), then a clean rerun
    fill_b(32'd2, 32'd3);
    clear_logs();
    kick_b();
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      if (bb.matrix_c_we && bb.row_addr_c == 2'd1 && bb.col_addr_c == 3'd2) found = 1;
      else @(negedge clk);
    end
    check("rst_mid_found_w12", found, 1);
    rstn_b = 1'b0;
    #1;
    check_idle_outputs_b("rst_mid_now");
    @(posedge clk);
    #1;
    check_idle_outputs_b("rst_mid_edge");
    @(negedge clk);
    rstn_b = 1'b1;
    clear_logs();
    kick_b();
    wait_done_b(at);
    check("rerun_done_at", at, 106);
    check_writes_b(67'd30);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
